mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage load/store unit. It consumes the EX/MEM pipeline register outputs (ALU result as address, RD2 as store data, control) and drives the data-memory request/grant/response bus.
- Handles RV32I byte, half and word accesses: lane steering, byte enables, load sign/zero extension and alignment checking.
- Stalls the pipeline until the memory transaction completes.
- Its registered load result feeds the MEM/WB register.

Parameters:
- DATA_WIDTH, 32, datapath and address width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ALUResultM_i  in  DATA_WIDTH  byte address
- WriteDataM_i  in  DATA_WIDTH  store data (RD2), right-aligned
- MemReadM_i  in  1  load request
- MemWriteM_i  in  1  store request
- Funct3M_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- mem_req_o  out  1  bus request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  DATA_WIDTH  word-aligned address (bits [1:0] = 0)
- mem_wdata_o  out  DATA_WIDTH  lane-shifted store data
- mem_be_o  out  4  byte enables
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  DATA_WIDTH  raw read word
- ReadDataM_o  out  DATA_WIDTH  extended load result
- stall_o  out  1  freeze upstream pipeline
- access_err_o  out  1  one-cycle error pulse

Behaviour:
- Reset (async, rst_n = 0):
  - State = IDLE.
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, ReadDataM_o and access_err_o all = 0.
  - Any in-flight transaction is abandoned; a later rvalid is ignored.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- stall_o = (IDLE and a legal op is presented) or state is REQ or WAIT_RSP. It is combinational and 0 in DONE.
- IDLE:
  - If neither MemReadM_i nor MemWriteM_i is set: stay in IDLE.
  - If an op is presented, check legality.
  - Illegal op: register access_err_o = 1 for one cycle, do not stall, stay in IDLE. Illegal means any of:
    - both MemReadM_i and MemWriteM_i high;
    - Funct3 is 011, 110 or 111 (loads), or anything other than 000/001/010 (stores);
    - half access with addr[0] = 1;
    - word access with addr[1:0] != 0.
  - Legal op: on the next edge, register the following, then go to REQ:
    - mem_addr_o = {addr[31:2], 2'b00}.
    - mem_we_o = MemWriteM_i.
    - Byte enables: B -> 4'b0001 << addr[1:0]; H -> 4'b0011 << addr[1:0]; W -> 4'b1111.
    - Write data: B -> byte replicated ×4; H -> half replicated ×2; W -> unchanged.
    - Offset and Funct3 held internally.
- REQ:
  - mem_req_o = 1; all bus outputs held stable until mem_gnt_i.
  - On gnt with a write: go to DONE.
  - On gnt with a read and mem_rvalid_i in the same cycle: capture data, go to DONE.
  - On gnt with a read otherwise: go to WAIT_RSP.
  - mem_req_o drops the cycle after gnt.
- WAIT_RSP: mem_req_o = 0; wait any number of cycles for mem_rvalid_i, then capture and go to DONE.
- Load capture (registered into ReadDataM_o):
  - Select the byte or half at the held offset.
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- ReadDataM_o holds its value until the next load capture. Stores do not change it.
- DONE: lasts exactly one cycle with stall_o = 0, so the pipeline advances; then IDLE.
- Minimum latency, gnt and rvalid immediate: op seen in IDLE (cycle 0), REQ (1), DONE (2), result valid from cycle 2.
- mem_rvalid_i outside REQ/WAIT_RSP is ignored. mem_gnt_i outside REQ is ignored.
- Upstream inputs must stay stable while stall_o = 1. The unit samples them only in IDLE.

Test Plan:
- LB, addr 0x1003, gnt and rvalid both asserted in REQ, rdata 0x80FF_0000 -> mem_addr_o 0x1000, mem_be_o 0001-shifted to 1000, ReadDataM_o 0xFFFF_FF80 at cycle 2, stall_o high exactly cycles 0–1.
- SH, addr 0x2002, data 0x1234_ABCD, gnt delayed 3 cycles -> mem_be_o 1100, mem_wdata_o 0xABCD_ABCD held stable over all 4 REQ cycles, mem_we_o 1, ReadDataM_o unchanged.
- LHU, addr 0x0, gnt at cycle 1, rvalid 2 cycles later (WAIT_RSP), rdata 0x0000_9ABC -> ReadDataM_o 0x0000_9ABC, stall_o low only in DONE.
- LW with addr 0x0006, and separately SH with addr 0x0001 -> access_err_o single-cycle pulse, mem_req_o never asserted, stall_o stays 0.
- Back-to-back SW 0x10 then LW 0x10 (rdata 0xDEAD_BEEF) -> two distinct transactions, one DONE cycle between them, final ReadDataM_o 0xDEAD_BEEF.
- rst_n pulsed low during WAIT_RSP, then rvalid arrives -> outputs zero asynchronously, FSM in IDLE, late rvalid ignored, ReadDataM_o stays 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I memory-stage load/store unit driving a req/gnt/rvalid data bus
module mem_access_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] ALUResultM_i,
  input  logic [DATA_WIDTH-1:0] WriteDataM_i,
  input  logic                  MemReadM_i,
  input  logic                  MemWriteM_i,
  input  logic [2:0]            Funct3M_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_be_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] ReadDataM_o,
  output logic                  stall_o,
  output logic                  access_err_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;
  state_t state;
  logic [1:0] off_q;
  logic [2:0] f3_q;
  logic op, bad_f3, misalign, legal;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;
  logic [DATA_WIDTH-1:0] load_val, wdata_n;
  logic [3:0] be_n;
  // request legality, lane steering for stores and extension of the captured load
  always_comb begin
    op       = MemReadM_i | MemWriteM_i;
    bad_f3   = MemWriteM_i ? (Funct3M_i[2] | (Funct3M_i[1:0] == 2'b11))
                           : ((Funct3M_i == 3'b011) | (Funct3M_i[2:1] == 2'b11));
    misalign = ((Funct3M_i[1:0] == 2'b01) & ALUResultM_i[0]) |
               ((Funct3M_i[1:0] == 2'b10) & (ALUResultM_i[1:0] != 2'b00));
    legal    = op & ~(MemReadM_i & MemWriteM_i) & ~bad_f3 & ~misalign;
    be_n     = (Funct3M_i[1:0] == 2'b00) ? 4'b0001 << ALUResultM_i[1:0] :
               (Funct3M_i[1:0] == 2'b01) ? 4'b0011 << ALUResultM_i[1:0] : 4'b1111;
    wdata_n  = (Funct3M_i[1:0] == 2'b00) ? {4{WriteDataM_i[7:0]}} :
               (Funct3M_i[1:0] == 2'b01) ? {2{WriteDataM_i[15:0]}} : WriteDataM_i;
    byte_sel = mem_rdata_i[{off_q, 3'b000} +: 8];
    half_sel = mem_rdata_i[{off_q[1], 4'b0000} +: 16];
    load_val = (f3_q[1:0] == 2'b00) ? {{(DATA_WIDTH-8){byte_sel[7] & ~f3_q[2]}}, byte_sel} :
               (f3_q[1:0] == 2'b01) ? {{(DATA_WIDTH-16){half_sel[15] & ~f3_q[2]}}, half_sel} :
               mem_rdata_i;
    stall_o  = ((state == IDLE) & legal) | (state == REQ) | (state == WAIT_RSP);
  end
  // transaction FSM with registered bus outputs, load result and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      mem_be_o     <= 4'b0000;
      ReadDataM_o  <= '0;
      access_err_o <= 1'b0;
      off_q        <= 2'b00;
      f3_q         <= 3'b000;
    end else begin
      access_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (legal) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= MemWriteM_i;
            mem_addr_o  <= {ALUResultM_i[DATA_WIDTH-1:2], 2'b00};
            mem_wdata_o <= wdata_n;
            mem_be_o    <= be_n;
            off_q       <= ALUResultM_i[1:0];
            f3_q        <= Funct3M_i;
            state       <= REQ;
          end else begin
            access_err_o <= op;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            if (mem_we_o) begin
              state <= DONE;
            end else if (mem_rvalid_i) begin
              ReadDataM_o <= load_val;
              state       <= DONE;
            end else begin
              state <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (mem_rvalid_i) begin
            ReadDataM_o <= load_val;
            state       <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scoreboard bench for mem_access_unit
module tb_mem_access_unit;
  logic        clk, rst_n;
  logic [31:0] addr, wd, rdata;
  logic        rd, wr, gnt, rvalid;
  logic [2:0]  f3;
  logic        req, we, stall, err;
  logic [31:0] maddr, mwdata, rdm;
  logic [3:0]  be;
  int compared = 0;
  int mismatched = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = 32'h0;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .ALUResultM_i(addr), .WriteDataM_i(wd),
    .MemReadM_i(rd), .MemWriteM_i(wr), .Funct3M_i(f3),
    .mem_req_o(req), .mem_we_o(we), .mem_addr_o(maddr),
    .mem_wdata_o(mwdata), .mem_be_o(be),
    .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
    .ReadDataM_o(rdm), .stall_o(stall), .access_err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d);
    rd = r; wr = w; f3 = f; addr = a; wd = d;
  endtask

  // DONE cycle: pipeline released; a pending load result is popped and compared
  task automatic done_check(input string tag);
    chk({tag, "_done_stall"}, {31'b0, stall}, 32'h0);
    chk({tag, "_done_req"}, {31'b0, req}, 32'h0);
    if (exp_q.size() > 0) last_rd = exp_q.pop_front();
    chk({tag, "_rdata"}, rdm, last_rd);
  endtask

  initial begin
    rst_n = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #3;
    chk("rst_req", {31'b0, req}, 32'h0);
    chk("rst_we", {31'b0, we}, 32'h0);
    chk("rst_addr", maddr, 32'h0);
    chk("rst_wdata", mwdata, 32'h0);
    chk("rst_be", {28'b0, be}, 32'h0);
    chk("rst_rdata", rdm, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    // LB 0x1003, gnt and rvalid together in REQ
    drive(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0);
    exp_q.push_back(32'hFFFF_FF80);
    #1 chk("lb_c0_stall", {31'b0, stall}, 32'h1);
    chk("lb_c0_req", {31'b0, req}, 32'h0);
    tick();
    chk("lb_req", {31'b0, req}, 32'h1);
    chk("lb_addr", maddr, 32'h0000_1000);
    chk("lb_be", {28'b0, be}, 32'h8);
    chk("lb_we", {31'b0, we}, 32'h0);
    chk("lb_c1_stall", {31'b0, stall}, 32'h1);
    gnt = 1'b1; rvalid = 1'b1; rdata = 32'h80FF_0000;
    tick();
    gnt = 1'b0; rvalid = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    done_check("lb");
    tick();
    chk("lb_c3_stall", {31'b0, stall}, 32'h0);
    // SH 0x2002 with grant held off for three REQ cycles
    drive(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("sh_req", {31'b0, req}, 32'h1);
      chk("sh_we", {31'b0, we}, 32'h1);
      chk("sh_be", {28'b0, be}, 32'hC);
      chk("sh_wdata", mwdata, 32'hABCD_ABCD);
      chk("sh_addr", maddr, 32'h0000_2000);
      chk("sh_stall", {31'b0, stall}, 32'h1);
      gnt = (i == 3);
      tick();
    end
    gnt = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    done_check("sh");
    tick();
    // LHU 0x0, grant in REQ, rvalid two cycles later
    drive(1'b1, 1'b0, 3'b101, 32'h0, 32'h0);
    exp_q.push_back(32'h0000_9ABC);
    tick();
    chk("lhu_be", {28'b0, be}, 32'h3);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("lhu_w1_req", {31'b0, req}, 32'h0);
    chk("lhu_w1_stall", {31'b0, stall}, 32'h1);
    tick();
    chk("lhu_w2_stall", {31'b0, stall}, 32'h1);
    rvalid = 1'b1; rdata = 32'h0000_9ABC;
    tick();
    rvalid = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    done_check("lhu");
    tick();
    // illegal requests: misaligned LW, misaligned SH, read+write together
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0);
    #1 chk("lw_mis_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("lw_mis_err", {31'b0, err}, 32'h1);
    chk("lw_mis_req", {31'b0, req}, 32'h0);
    drive(1'b0, 1'b1, 3'b001, 32'h0000_0001, 32'h0);
    #1 chk("sh_mis_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("sh_mis_err", {31'b0, err}, 32'h1);
    chk("sh_mis_req", {31'b0, req}, 32'h0);
    drive(1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'h0);
    tick();
    chk("rw_err", {31'b0, err}, 32'h1);
    drive(1'b1, 1'b0, 3'b110, 32'h0000_0010, 32'h0);
    tick();
    chk("f3_err", {31'b0, err}, 32'h1);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    chk("err_pulse_end", {31'b0, err}, 32'h0);
    chk("err_req", {31'b0, req}, 32'h0);
    // back-to-back SW then LW at 0x10
    drive(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h0000_0055);
    tick();
    chk("sw_wdata", mwdata, 32'h0000_0055);
    chk("sw_be", {28'b0, be}, 32'hF);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    done_check("sw");
    tick();
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0);
    exp_q.push_back(32'hDEAD_BEEF);
    #1 chk("lw_c0_stall", {31'b0, stall}, 32'h1);
    tick();
    chk("lw_req", {31'b0, req}, 32'h1);
    chk("lw_we", {31'b0, we}, 32'h0);
    chk("lw_addr", maddr, 32'h0000_0010);
    gnt = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    tick();
    gnt = 1'b0; rvalid = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    done_check("lw");
    tick();
    // reset during WAIT_RSP abandons the load; late rvalid ignored
    drive(1'b1, 1'b0, 3'b100, 32'h0000_0020, 32'h0);
    tick();
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("rstw_stall", {31'b0, stall}, 32'h1);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1 rst_n = 1'b0;
    #1 chk("rstw_rdata", rdm, 32'h0);
    chk("rstw_stall0", {31'b0, stall}, 32'h0);
    chk("rstw_addr", maddr, 32'h0);
    chk("rstw_be", {28'b0, be}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    rvalid = 1'b1; rdata = 32'h1234_5678;
    tick();
    rvalid = 1'b0;
    chk("late_rdata", rdm, 32'h0);
    chk("late_req", {31'b0, req}, 32'h0);
    chk("late_stall", {31'b0, stall}, 32'h0);
    chk("sb_empty", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
